// File: rtl/slot_reel_engine.sv
// slot_reel_engine
//   Reel-spin and outcome generator. A play accepted while credit is
//   available spins three reels from a free-running LFSR, freezes them one
//   after another, judges the symbols and pulses result_valid with a win code.
//
// Build option:
//   SLOT_PAIR_WIN_EN  defined   -> exactly two equal symbols score win=01
//                     undefined -> only a triple scores (win=10)
//
// Ports:
//   clk           system clock
//   clear_n       asynchronous active-low reset
//   start         single-cycle play request
//   credit_ok     balance non-zero; sampled only when start is accepted
//   reel0..reel2  current symbol on each reel (3 bits each)
//   win           00 lose, 01 pair, 10 triple; held until the next judgement
//   result_valid  one-cycle pulse, win valid in this cycle
//   busy          high from the cycle after acceptance through result_valid

module slot_reel_engine #(
    parameter int PRESCALE   = 2,
    parameter int SPIN_TICKS = 4,
    parameter int STAGGER    = 2
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       start,
    input  logic       credit_ok,
    output logic [2:0] reel0,
    output logic [2:0] reel1,
    output logic [2:0] reel2,
    output logic [1:0] win,
    output logic       result_valid,
    output logic       busy
);

    localparam int TOTAL = SPIN_TICKS + 2 * STAGGER;
    localparam int TW    = $clog2(TOTAL + 1);
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [TW-1:0] FREEZE0  = TW'(SPIN_TICKS);
    localparam logic [TW-1:0] FREEZE1  = TW'(SPIN_TICKS + STAGGER);
    localparam logic [TW-1:0] FREEZE2  = TW'(TOTAL);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        JUDGE,
        DONE
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [PW-1:0] presc_cnt;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_next;
    logic          frz0;
    logic          frz1;
    logic          tick;
    logic          triple;
    logic [1:0]    win_next;

    // Galois LFSR, x^16+x^14+x^13+x^11+1; free-running so the outcome
    // depends on when the player presses start.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        end
    end

    always_comb begin
        tick      = (state == SPIN) && (presc_cnt == PRE_LAST);
        tick_next = tick_cnt + 1'b1;
        triple    = (reel0 == reel1) && (reel1 == reel2);
    end

`ifdef SLOT_PAIR_WIN_EN
    logic pair_any;
    always_comb begin
        pair_any = (reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2);
        win_next = triple ? 2'b10 : (pair_any ? 2'b01 : 2'b00);
    end
`else
    always_comb begin
        win_next = triple ? 2'b10 : 2'b00;
    end
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state        <= IDLE;
            reel0        <= '0;
            reel1        <= '0;
            reel2        <= '0;
            win          <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            presc_cnt    <= '0;
            tick_cnt     <= '0;
            frz0         <= 1'b0;
            frz1         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    presc_cnt <= '0;
                    tick_cnt  <= '0;
                    frz0      <= 1'b0;
                    frz1      <= 1'b0;
                    if (start && credit_ok) begin
                        state <= SPIN;
                        busy  <= 1'b1;
                    end
                end
                SPIN: begin
                    presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                    if (tick) begin
                        tick_cnt <= tick_next;
                        if (!frz0) reel0 <= lfsr[2:0];
                        if (!frz1) reel1 <= lfsr[5:3];
                        // reel 2 is the last to freeze, which is also the
                        // moment SPIN ends, so it needs no flag of its own
                        reel2 <= lfsr[8:6];
                        if (tick_next == FREEZE0) frz0 <= 1'b1;
                        if (tick_next == FREEZE1) frz1 <= 1'b1;
                        if (tick_next == FREEZE2) state <= JUDGE;
                    end
                end
                JUDGE: begin
                    win          <= win_next;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_reel_engine.sv
// Testbench for slot_reel_engine. A reference LFSR model tracks the DUT's
// free-running LFSR; each accepted play pushes the predicted final reels and
// win code onto a scoreboard queue that is popped when result_valid fires.
`timescale 1ns/1ps
module tb_slot_reel_engine;

    localparam int P   = 2;
    localparam int S   = 4;
    localparam int G   = 2;
    localparam int T0  = P * S;
    localparam int T1  = P * (S + G);
    localparam int T2  = P * (S + 2 * G);
    localparam int LAT = T2 + 2;

`ifdef SLOT_PAIR_WIN_EN
    localparam logic [1:0] PAIR_CODE = 2'b01;
`else
    localparam logic [1:0] PAIR_CODE = 2'b00;
`endif

    typedef struct packed {
        logic [2:0] r0;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [1:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear_n = 1'b1;
    logic       start = 1'b0;
    logic       credit_ok = 1'b0;
    logic [2:0] reel0, reel1, reel2;
    logic [1:0] win;
    logic       result_valid, busy;

    int checks = 0;
    int failures = 0;

    exp_t        sb[$];
    logic [15:0] m_lfsr;

    slot_reel_engine #(
        .PRESCALE  (P),
        .SPIN_TICKS(S),
        .STAGGER   (G)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .start       (start),
        .credit_ok   (credit_ok),
        .reel0       (reel0),
        .reel1       (reel1),
        .reel2       (reel2),
        .win         (win),
        .result_valid(result_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] adv(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Reference LFSR: reseeds on reset, advances every clock.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= adv(m_lfsr);
    end

    // l0 is the LFSR value during the acceptance cycle (cycle 0). During
    // cycle c it is adv^c(l0); reel k takes its last load at the tick in
    // cycle P*(S+k*G).
    function automatic exp_t predict(input logic [15:0] l0);
        exp_t e;
        logic [15:0] l;
        e = '0;
        l = l0;
        for (int c = 0; c <= T2; c++) begin
            if (c == T0) e.r0 = l[2:0];
            if (c == T1) e.r1 = l[5:3];
            if (c == T2) e.r2 = l[8:6];
            l = adv(l);
        end
        if (e.r0 == e.r1 && e.r1 == e.r2)
            e.w = 2'b10;
        else if (e.r0 == e.r1 || e.r1 == e.r2 || e.r0 == e.r2)
            e.w = PAIR_CODE;
        else
            e.w = 2'b00;
        return e;
    endfunction

    function automatic int cat_of(input exp_t e);
        if (e.r0 == e.r1 && e.r1 == e.r2) return 2;
        if (e.r0 == e.r1 || e.r1 == e.r2 || e.r0 == e.r2) return 1;
        return 0;
    endfunction

    task automatic test_reset();
        clear_n   = 1'b1;
        start     = 1'b0;
        credit_ok = 1'b0;
        #1 clear_n = 1'b0;
        #1;
        checks++;
        if ({reel0, reel1, reel2} !== 9'd0) begin
            failures++;
            $display("FAIL reset_reels: got %0d,%0d,%0d expected 0,0,0", reel0, reel1, reel2);
        end
        checks++;
        if ({win, result_valid, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got win=%b rv=%b busy=%b expected 00,0,0", win, result_valid, busy);
        end
        checks++;
        if (dut.lfsr !== 16'hACE1) begin
            failures++;
            $display("FAIL reset_seed: got %h expected ace1", dut.lfsr);
        end
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({reel0, reel1, reel2, win, result_valid, busy} !== 13'd0) begin
                failures++;
                $display("FAIL idle_outputs: cycle %0d got r=%0d,%0d,%0d win=%b rv=%b busy=%b expected all 0",
                         c, reel0, reel1, reel2, win, result_valid, busy);
            end
            checks++;
            if (dut.lfsr !== m_lfsr) begin
                failures++;
                $display("FAIL idle_lfsr: cycle %0d got %h expected %h", c, dut.lfsr, m_lfsr);
            end
        end
    endtask

    task automatic test_timing();
        exp_t e;
        exp_t fin;
        int   got;
        credit_ok = 1'b1;
        fin = predict(m_lfsr);
        sb.push_back(fin);
        start = 1'b1;
        got = 0;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            checks++;
            if (busy !== (c <= LAT)) begin
                failures++;
                $display("FAIL timing_busy: cycle %0d got %b expected %b", c, busy, (c <= LAT));
            end
            checks++;
            if (result_valid !== (c == LAT)) begin
                failures++;
                $display("FAIL timing_rv: cycle %0d got %b expected %b", c, result_valid, (c == LAT));
            end
            if (c > T0) begin
                checks++;
                if (reel0 !== fin.r0) begin
                    failures++;
                    $display("FAIL timing_reel0_hold: cycle %0d got %0d expected %0d", c, reel0, fin.r0);
                end
            end
            if (c > T1) begin
                checks++;
                if (reel1 !== fin.r1) begin
                    failures++;
                    $display("FAIL timing_reel1_hold: cycle %0d got %0d expected %0d", c, reel1, fin.r1);
                end
            end
            if (c > T2) begin
                checks++;
                if (reel2 !== fin.r2) begin
                    failures++;
                    $display("FAIL timing_reel2_hold: cycle %0d got %0d expected %0d", c, reel2, fin.r2);
                end
            end
            if (result_valid === 1'b1) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL timing_unexpected_result: cycle %0d got result expected none", c);
                end else begin
                    e = sb.pop_front();
                    if (win !== e.w) begin
                        failures++;
                        $display("FAIL timing_win: got %b expected %b", win, e.w);
                    end
                end
            end
        end
        checks++;
        if (got != 1) begin
            failures++;
            $display("FAIL timing_result_count: got %0d expected 1", got);
        end
    endtask

    task automatic test_outcome(input string name, input logic [2:0] a, input logic [2:0] b,
                                input logic [2:0] c3, input int cat, input logic [1:0] wexp);
        exp_t        e;
        logic [15:0] l;
        int          d;
        int          got;
        d = -1;
        l = m_lfsr;
        for (int i = 0; i < 8000; i++) begin
            e = predict(l);
            if (e.r0 == a && e.r1 == b && e.r2 == c3) begin
                d = i;
                break;
            end
            l = adv(l);
        end
        if (d < 0) begin
            l = m_lfsr;
            for (int i = 0; i < 4000; i++) begin
                e = predict(l);
                if (cat_of(e) == cat) begin
                    d = i;
                    break;
                end
                l = adv(l);
            end
        end
        checks++;
        if (d < 0) begin
            failures++;
            $display("FAIL %s_search: got no start offset expected one within bound", name);
            return;
        end
        repeat (d) @(negedge clk);
        e = predict(m_lfsr);
        sb.push_back(e);
        credit_ok = 1'b1;
        start = 1'b1;
        got = 0;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (result_valid === 1'b1) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s_unexpected_result: cycle %0d got result expected none", name, c);
                end else begin
                    e = sb.pop_front();
                    if (win !== wexp) begin
                        failures++;
                        $display("FAIL %s_win: reels %0d,%0d,%0d got %b expected %b",
                                 name, reel0, reel1, reel2, win, wexp);
                    end
                    checks++;
                    if ({reel0, reel1, reel2} !== {e.r0, e.r1, e.r2}) begin
                        failures++;
                        $display("FAIL %s_reels: got %0d,%0d,%0d expected %0d,%0d,%0d",
                                 name, reel0, reel1, reel2, e.r0, e.r1, e.r2);
                    end
                end
            end
        end
        checks++;
        if (got != 1) begin
            failures++;
            $display("FAIL %s_result_count: got %0d expected 1", name, got);
        end
    endtask

    task automatic test_ignored();
        exp_t e;
        int   got;
        credit_ok = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            checks++;
            if (busy !== 1'b0 || result_valid !== 1'b0) begin
                failures++;
                $display("FAIL nocredit_idle: cycle %0d got busy=%b rv=%b expected 0,0", c, busy, result_valid);
            end
        end
        credit_ok = 1'b1;
        sb.push_back(predict(m_lfsr));
        start = 1'b1;
        got = 0;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== (c <= LAT) || result_valid !== (c == LAT)) begin
                failures++;
                $display("FAIL busy_start: cycle %0d got busy=%b rv=%b expected %b,%b",
                         c, busy, result_valid, (c <= LAT), (c == LAT));
            end
            if (result_valid === 1'b1) begin
                got++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (win !== e.w) begin
                        failures++;
                        $display("FAIL busy_start_win: got %b expected %b", win, e.w);
                    end
                end
            end
            if (c == 1) start = 1'b0;
            if (c == 3) credit_ok = 1'b0;
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
        end
        checks++;
        if (got != 1) begin
            failures++;
            $display("FAIL busy_start_result_count: got %0d expected 1", got);
        end
        credit_ok = 1'b1;
    endtask

    task automatic test_reset_mid();
        credit_ok = 1'b1;
        sb.push_back(predict(m_lfsr));
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        clear_n = 1'b0;
        #1;
        checks++;
        if ({reel0, reel1, reel2, win, result_valid, busy} !== 13'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got r=%0d,%0d,%0d win=%b rv=%b busy=%b expected all 0",
                     reel0, reel1, reel2, win, result_valid, busy);
        end
        checks++;
        if (dut.lfsr !== 16'hACE1) begin
            failures++;
            $display("FAIL midreset_seed: got %h expected ace1", dut.lfsr);
        end
        @(negedge clk);
        clear_n = 1'b1;
        sb.delete();
        for (int c = 0; c < LAT + 6; c++) begin
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet: cycle %0d got rv=%b busy=%b expected 0,0", c, result_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   got;
        logic exp_busy;
        logic exp_rv;
        credit_ok = 1'b1;
        sb.push_back(predict(m_lfsr));
        start = 1'b1;
        got = 0;
        for (int c = 1; c <= 2 * LAT + 4; c++) begin
            @(negedge clk);
            exp_rv   = (c == LAT) || (c == 2 * LAT + 1);
            exp_busy = (c <= LAT) || (c >= LAT + 2 && c <= 2 * LAT + 1);
            checks++;
            if (busy !== exp_busy || result_valid !== exp_rv) begin
                failures++;
                $display("FAIL b2b_timing: cycle %0d got busy=%b rv=%b expected %b,%b",
                         c, busy, result_valid, exp_busy, exp_rv);
            end
            if (result_valid === 1'b1) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_result: cycle %0d got result expected none", c);
                end else begin
                    e = sb.pop_front();
                    if (win !== e.w || {reel0, reel1, reel2} !== {e.r0, e.r1, e.r2}) begin
                        failures++;
                        $display("FAIL b2b_result: got win=%b r=%0d,%0d,%0d expected win=%b r=%0d,%0d,%0d",
                                 win, reel0, reel1, reel2, e.w, e.r0, e.r1, e.r2);
                    end
                end
            end
            if (c == 1) start = 1'b0;
            if (c == LAT + 1) begin
                sb.push_back(predict(m_lfsr));
                start = 1'b1;
            end
            if (c == LAT + 2) start = 1'b0;
        end
        checks++;
        if (got != 2) begin
            failures++;
            $display("FAIL b2b_result_count: got %0d expected 2", got);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_outcome("triple", 3'd5, 3'd5, 3'd5, 2, 2'b10);
        test_outcome("pair", 3'd5, 3'd5, 3'd2, 1, PAIR_CODE);
        test_outcome("lose", 3'd1, 3'd2, 3'd3, 0, 2'b00);
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slot_reel_engine.md
# slot_reel_engine

Reel-spin and outcome generator for the slot-machine datapath. It sits directly upstream of the money controller. When a play is requested and credit is available, it spins three pseudo-random reels and stops them one after another. It then judges the final symbols and delivers a one-cycle result with a 2-bit win code, which the money controller adds to or deducts from the balance.

## Interface
Parameters:
- PRESCALE, 2: clocks per reel tick (≥1).
- SPIN_TICKS, 4: ticks before reel 0 freezes (≥1).
- STAGGER, 2: ticks between successive reel freezes (≥1).

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- clear_n  in  1  asynchronous, active-low reset.
- start  in  1  play request, single-cycle active-high pulse (debounced upstream).
- credit_ok  in  1  high when balance is non-zero; gates acceptance of start.
- reel0, reel1, reel2  out  3 each  current symbol on each reel.
- win  out  2  result code: 00 lose, 01 pair, 10 triple; 11 is never driven.
- result_valid  out  1  one-cycle pulse; win is valid in this cycle.
- busy  out  1  high from the cycle after acceptance through the result_valid cycle.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Seeds to 16'hACE1 on reset and advances every clk, including while idle, so the outcome depends on press timing.
- Tick generator: counts 0..PRESCALE-1 and emits tick on terminal count. Restarts at 0 on start acceptance; held at 0 in IDLE.
- States:
  - IDLE: start && credit_ok → SPIN. tick_cnt and freeze flags clear.
  - SPIN: on each tick, every unfrozen reel k loads lfsr[3k+2:3k]. Frozen reels hold. A tick counter advances on each tick. Reel 0 freezes after SPIN_TICKS ticks, reel 1 after SPIN_TICKS+STAGGER, reel 2 after SPIN_TICKS+2·STAGGER. When reel 2 freezes → JUDGE.
  - JUDGE (1 cycle):
    - All three symbols equal → win=10.
    - Otherwise, any two equal → 01 (see Configuration).
    - Otherwise → 00.
    - Go to DONE.
  - DONE (1 cycle): result_valid=1, busy=1 → IDLE.
- win holds its value until the next JUDGE. Reels hold their final symbols in IDLE.
- start while busy: ignored, not queued.
- start with credit_ok=0: ignored; state stays IDLE and there is no result.
- credit_ok is sampled only at acceptance. Dropping it mid-spin has no effect.

## Timing
- Reset values (async, clear_n low): state IDLE, reel0..2=0, win=00, result_valid=0, busy=0, lfsr=16'hACE1, all counters 0.
- Reset mid-spin: immediate return to IDLE with all outputs at reset values. No result_valid is emitted.
- Acceptance edge = cycle 0. busy rises in cycle 1.
- The first tick occurs PRESCALE cycles after acceptance.
- result_valid is high in cycle PRESCALE·(SPIN_TICKS+2·STAGGER)+2. With the defaults this is cycle 18.
- busy falls in the cycle after result_valid. A start in that same cycle is accepted, giving a back-to-back play.
- PRESCALE=1: tick is every cycle. The formula above still holds.
- Internal tick counters are sized to SPIN_TICKS+2·STAGGER and never wrap within a play.

## Configuration
- SLOT_PAIR_WIN_EN defined: a pair (exactly two equal symbols) yields win=01.
- SLOT_PAIR_WIN_EN undefined: pairs yield win=00; only a triple scores, with win=10.
- Nothing else changes: timing, states and reel behaviour are identical in both builds.

## Test plan
- Reset, then idle 10 cycles → reels=0, win=00, busy=0, result_valid=0; lfsr sequence matches the reference model from 16'hACE1.
- start with credit_ok=1 at cycle 0 (defaults) → busy=1 in cycles 1–18; reel0 stops changing after cycle 8, reel1 after 12, reel2 after 16; result_valid is high only in cycle 18.
- Force LFSR via model so final reels are 5,5,5 → win=10. For 5,5,2 → win=01 with SLOT_PAIR_WIN_EN, 00 without. For 1,2,3 → win=00.
- start with credit_ok=0, then start at cycle 5 during busy → no acceptance in the first case; in the second, only one result_valid, at the original cycle 18.
- Pulse clear_n low at cycle 10 mid-spin → all outputs return to reset values immediately; no result_valid follows.
- start asserted in the cycle after result_valid → second play accepted, with its result_valid 18 cycles later.
